mdc_out_merger: RTL

Downstream merge stage for the multi-dataflow network. It consumes the two network output streams, `out0` and `out1`, through the same `data/full_n/write` FIFO-writer handshake the network drives. It buffers each stream in a small per-channel FIFO and serialises both onto one tagged output stream using round-robin arbitration. It also keeps per-channel forwarded-word counters for monitoring.

---
 rtl/mdc_out_merger_if.sv | 11 +
 rtl/mdc_out_merger.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mdc_out_merger_if.sv
// FIFO-writer style stream: producer drives data/write, consumer answers full_n.
interface mdc_out_merger_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             write;
  logic             full_n;

  modport master (output data, output write, input full_n);
  modport slave  (input data, input write, output full_n);
endinterface

// File: rtl/mdc_out_merger.sv
// Merges two FIFO-writer streams into one tagged stream with round-robin
// arbitration, per-channel buffering and forwarded-word counters.
module mdc_out_merger #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  mdc_out_merger_if.slave         in0,
  mdc_out_merger_if.slave         in1,
  mdc_out_merger_if.master        out,
  output logic                    out_tag,
  output logic [15:0]             count0,
  output logic [15:0]             count1
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [1:0]            wr;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            nonempty;
  logic [1:0]            full_n;
  logic [1:0][WIDTH-1:0] wdata;
  logic [1:0][WIDTH-1:0] head;

  logic                  valid_q;
  logic                  tag_q;
  logic                  last_grant_q;
  logic [WIDTH-1:0]      data_q;
  logic [15:0]           count0_q;
  logic [15:0]           count1_q;

  logic                  load;
  logic                  xfer;
  logic                  sel;

  assign wr         = {in1.write, in0.write};
  assign wdata      = {in1.data, in0.data};
  assign in0.full_n = full_n[0];
  assign in1.full_n = full_n[1];
  assign push       = wr & full_n;

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             full_n_q;

    always_comb begin
      cnt_d = cnt_q + (AW + 1)'(push[k]) - (AW + 1)'(pop[k]);
    end

    always_ff @(posedge ap_clk) begin
      if (push[k]) begin
        mem_q[wr_ptr_q] <= wdata[k];
      end
    end

    // full_n comes from next-state occupancy so it stays register-derived;
    // its reset value of 0 also blocks the first edge after release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        full_n_q <= 1'b0;
      end else begin
        if (push[k]) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop[k]) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        cnt_q    <= cnt_d;
        full_n_q <= (cnt_d != FULL_CNT);
      end
    end

    assign nonempty[k] = (cnt_q != '0);
    assign head[k]     = mem_q[rd_ptr_q];
    assign full_n[k]   = full_n_q;
  end

  always_comb begin
    load = !valid_q || out.full_n;
    xfer = valid_q && out.full_n;
    sel  = (&nonempty) ? ~last_grant_q : nonempty[1];
    pop  = {sel, ~sel} & {2{load && (|nonempty)}};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q      <= 1'b0;
      tag_q        <= 1'b0;
      data_q       <= '0;
      last_grant_q <= 1'b1;
      count0_q     <= '0;
      count1_q     <= '0;
    end else begin
      if (load) begin
        if (|nonempty) begin
          data_q       <= head[sel];
          tag_q        <= sel;
          valid_q      <= 1'b1;
          last_grant_q <= sel;
        end else begin
          valid_q <= 1'b0;
        end
      end
      if (xfer) begin
        if (tag_q) begin
          count1_q <= count1_q + 16'd1;
        end else begin
          count0_q <= count0_q + 16'd1;
        end
      end
    end
  end

  assign out.data  = data_q;
  assign out.write = valid_q;
  assign out_tag   = tag_q;
  assign count0    = count0_q;
  assign count1    = count1_q;

endmodule
